// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode, funct and ALU-operation definitions shared by the core
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_SUB  = 7'h20;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLL,
      ALU_SRL
   } alu_op_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - 32-bit ALU, modulo arithmetic, logical right shift
module riscv_alu
   import riscv_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   always_comb begin
      y = a + b;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLL: y = a << b[4:0];
         ALU_SRL: y = a >> b[4:0];
         default: y = a + b;
      endcase
   end

endmodule

// File: rtl/riscv_dmem.sv
// rtl/riscv_dmem.sv - byte-addressed data RAM, async read, sync byte write
module riscv_dmem #(
   parameter int DMEM_DEPTH = 128,
   parameter int AW         = $clog2(DMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wd,
   output logic [7:0]    rd
);

   logic [7:0] mem [0:DMEM_DEPTH-1];

   assign rd = mem[addr];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wd;
   end

endmodule

// File: rtl/riscv_imem.sv
// rtl/riscv_imem.sv - word-addressed instruction ROM, contents preloaded externally
module riscv_imem #(
   parameter int IMEM_DEPTH = 256,
   parameter int AW         = $clog2(IMEM_DEPTH)
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   data
);

   logic [31:0] Memory [0:IMEM_DEPTH-1];

   assign data = Memory[addr];

endmodule

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32x32 register file, two async read ports, one sync write port
module riscv_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [0:31];

   // x0 is forced to zero on read so a stale array entry can never leak out
   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

   always_ff @(posedge clk) begin
      if (we && wa != 5'd0)
         regs[wa] <= wd;
   end

endmodule

// File: rtl/riscv_core.sv
// rtl/riscv_core.sv - single-cycle RV32I subset core; RISCV_HALT_EN freezes pc on unsupported words
module riscv_core
   import riscv_pkg::*;
#(
   parameter int          IMEM_DEPTH = 256,
   parameter int          DMEM_DEPTH = 128,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc
);

   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);

   logic [31:0] instr;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b;
   logic [31:0] rs1_val, rs2_val, alu_b, alu_y, wb_data, next_pc;
   logic [7:0]  load_byte;
   logic        legal, reg_we, mem_we, use_imm, is_load, is_branch, taken;
   alu_op_t     alu_op;
   logic [IW+1:0] unused_pc;

   assign unused_pc = {pc[31:IW+2], pc[1:0]};

   riscv_imem #(.IMEM_DEPTH(IMEM_DEPTH)) instmemo (
      .addr (pc[IW+1:2]),
      .data (instr)
   );

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = sext12(instr[31:20]);
   assign imm_s = sext12({instr[31:25], instr[11:7]});
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   always_comb begin
      legal     = 1'b0;
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      use_imm   = 1'b0;
      is_load   = 1'b0;
      is_branch = 1'b0;
      alu_op    = ALU_ADD;
      case (opcode)
         OP_R: begin
            legal  = 1'b1;
            reg_we = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
               {F7_SUB,  F3_ADD}: alu_op = ALU_SUB;
               {F7_BASE, F3_AND}: alu_op = ALU_AND;
               {F7_BASE, F3_OR}:  alu_op = ALU_OR;
               {F7_BASE, F3_SLL}: alu_op = ALU_SLL;
               {F7_BASE, F3_SRL}: alu_op = ALU_SRL;
               default: begin
                  legal  = 1'b0;
                  reg_we = 1'b0;
               end
            endcase
         end
         OP_I: begin
            legal   = 1'b1;
            reg_we  = 1'b1;
            use_imm = 1'b1;
            case (funct3)
               F3_ADD:  alu_op = ALU_ADD;
               F3_AND:  alu_op = ALU_AND;
               F3_OR:   alu_op = ALU_OR;
               default: begin
                  legal  = 1'b0;
                  reg_we = 1'b0;
               end
            endcase
         end
         OP_LOAD: begin
            if (funct3 == F3_LB) begin
               legal   = 1'b1;
               reg_we  = 1'b1;
               use_imm = 1'b1;
               is_load = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_SB) begin
               legal   = 1'b1;
               mem_we  = 1'b1;
               use_imm = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
               legal     = 1'b1;
               is_branch = 1'b1;
            end
         end
         default: legal = 1'b0;
      endcase
   end

   riscv_regfile regs (
      .clk (clk),
      .we  (reg_we & legal & ~reset),
      .ra1 (rs1),
      .ra2 (rs2),
      .wa  (rd),
      .wd  (wb_data),
      .rd1 (rs1_val),
      .rd2 (rs2_val)
   );

   assign alu_b = !use_imm ? rs2_val : (opcode == OP_STORE) ? imm_s : imm_i;

   riscv_alu alu (
      .op (alu_op),
      .a  (rs1_val),
      .b  (alu_b),
      .y  (alu_y)
   );

   // Loads and stores reuse the ALU adder for the effective address
   riscv_dmem #(.DMEM_DEPTH(DMEM_DEPTH)) datamem (
      .clk  (clk),
      .we   (mem_we & legal & ~reset),
      .addr (alu_y[DW-1:0]),
      .wd   (rs2_val[7:0]),
      .rd   (load_byte)
   );

   assign wb_data = is_load ? {{24{load_byte[7]}}, load_byte} : alu_y;
   assign taken   = is_branch && ((funct3 == F3_BNE) ? (rs1_val != rs2_val) : (rs1_val == rs2_val));

   always_comb begin
      next_pc = taken ? pc + imm_b : pc + 32'd4;
`ifdef RISCV_HALT_EN
      if (!legal)
         next_pc = pc;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else
         pc <= next_pc;
   end

endmodule

// File: tb/tb_riscv_core.sv
// tb/tb_riscv_core.sv - directed and randomized checks of riscv_core against an instruction-level model
module tb_riscv_core;

   localparam int IMEM = 256;
   localparam int DMEM = 128;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [0:31];
   logic [7:0]  m_mem  [0:DMEM-1];
   logic [31:0] m_imem [0:IMEM-1];
   logic [31:0] m_pc;

   riscv_core #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .pc    (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      logic [12:0] o;
      o = off[12:0];
      return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
   endfunction

   task automatic set_reg(input int i, input logic [31:0] v);
      dut.regs.regs[i] = v;
      m_regs[i] = (i == 0) ? 32'd0 : v;
   endtask

   task automatic set_mem(input int a, input logic [7:0] v);
      dut.datamem.mem[a] = v;
      m_mem[a] = v;
   endtask

   task automatic load_prog(input logic [31:0] prog [$]);
      for (int i = 0; i < IMEM; i++) begin
         dut.instmemo.Memory[i] = 32'd0;
         m_imem[i] = 32'd0;
      end
      foreach (prog[i]) begin
         dut.instmemo.Memory[i] = prog[i];
         m_imem[i] = prog[i];
      end
   endtask

   // Instruction-set-level model: one architectural instruction per call
   task automatic model_exec();
      logic [31:0] ins, a, b, ii, is, ib, res, nxt;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        ok, wr;
      int          addr;
      ins = m_imem[(m_pc / 4) % IMEM];
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
      a  = (ins[19:15] == 0) ? 32'd0 : m_regs[ins[19:15]];
      b  = (ins[24:20] == 0) ? 32'd0 : m_regs[ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ok = 1'b1; wr = 1'b1; res = 32'd0; nxt = m_pc + 4;
      if      (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) res = a + b;
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) res = a - b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) res = a & b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) res = a | b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd1) res = a << b[4:0];
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd5) res = a >> b[4:0];
      else if (op == 7'h13 && f3 == 3'd0) res = a + ii;
      else if (op == 7'h13 && f3 == 3'd7) res = a & ii;
      else if (op == 7'h13 && f3 == 3'd6) res = a | ii;
      else if (op == 7'h03 && f3 == 3'd0) begin
         addr = int'((a + ii) % DMEM);
         res = {{24{m_mem[addr][7]}}, m_mem[addr]};
      end else if (op == 7'h23 && f3 == 3'd0) begin
         wr = 1'b0;
         addr = int'((a + is) % DMEM);
         m_mem[addr] = b[7:0];
      end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
         wr = 1'b0;
         if ((f3 == 3'd0) == (a == b)) nxt = m_pc + ib;
      end else begin
         ok = 1'b0;
         wr = 1'b0;
      end
      if (wr && rd != 0) m_regs[rd] = res;
`ifdef RISCV_HALT_EN
      if (!ok) nxt = m_pc;
`else
      if (!ok) nxt = m_pc + 4;
`endif
      m_pc = nxt;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         model_exec();
         @(posedge clk); #1;
         check("step_pc", pc, m_pc);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("reset_pc", pc, 32'h0);
      end
      reset = 1'b0;
      m_pc = 32'h0;
   endtask

   function automatic logic [31:0] rand_instr(input int plen);
      int k, off;
      logic [4:0] rd, r1, r2;
      logic [11:0] imm;
      logic [31:0] w;
      k = $urandom_range(0, 14);
      rd = 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      imm = 12'($urandom);
      off = ($urandom_range(0, 8) - 4) * 4;
      w = $urandom;
      case (k)
         0:  return enc_r(7'h00, r2, r1, 3'd0, rd);
         1:  return enc_r(7'h20, r2, r1, 3'd0, rd);
         2:  return enc_r(7'h00, r2, r1, 3'd7, rd);
         3:  return enc_r(7'h00, r2, r1, 3'd6, rd);
         4:  return enc_r(7'h00, r2, r1, 3'd1, rd);
         5:  return enc_r(7'h00, r2, r1, 3'd5, rd);
         6:  return enc_i(imm, r1, 3'd0, rd, 7'h13);
         7:  return enc_i(imm, r1, 3'd7, rd, 7'h13);
         8:  return enc_i(imm, r1, 3'd6, rd, 7'h13);
         9:  return enc_i(imm, r1, 3'd0, rd, 7'h03);
         10: return enc_s(imm, r2, r1);
         11: return enc_b(off, r2, r1, 3'd0);
         12: return enc_b(off, r2, r1, 3'd1);
         13: return enc_r(7'h20, r2, r1, 3'd7, rd);
         default: return ($urandom_range(0, 1) == 0) ? 32'd0 : {w[31:7], 7'h0B};
      endcase
   endfunction

   initial begin
      logic [31:0] prog [$];
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
      for (int i = 0; i < DMEM; i++) set_mem(i, 8'd0);
      load_prog('{});

      // lb sign extension
      set_mem(0, 8'h07);
      set_mem(1, 8'h80);
      load_prog('{enc_i(12'd0, 5'd0, 3'd0, 5'd5, 7'h03), enc_i(12'd1, 5'd0, 3'd0, 5'd13, 7'h03)});
      do_reset(1);
      step(2);
      check("lb_x5", dut.regs.regs[5], 32'h0000_0007);
      check("lb_x13", dut.regs.regs[13], 32'hFFFF_FF80);

      // sub / and / ori
      set_reg(5, 32'h7);
      set_reg(1, 32'h0000_F000);
      load_prog('{enc_r(7'h20, 5'd5, 5'd5, 3'd0, 5'd6), enc_r(7'h00, 5'd5, 5'd6, 3'd7, 5'd7),
                  enc_i(12'h0F0, 5'd1, 3'd6, 5'd8, 7'h13)});
      set_reg(6, 32'hAAAA_AAAA);
      set_reg(7, 32'h5555_5555);
      do_reset(1);
      step(3);
      check("sub_x6", dut.regs.regs[6], 32'h0);
      check("and_x7", dut.regs.regs[7], 32'h0);
      check("ori_x8", dut.regs.regs[8], 32'h0000_F0F0);

      // srl and sb leaving neighbours untouched
      set_reg(10, 32'h18);
      set_reg(11, 32'h3);
      set_reg(12, 32'hF);
      set_mem(3, 8'hAA);
      set_mem(4, 8'h00);
      set_mem(5, 8'hBB);
      load_prog('{enc_r(7'h00, 5'd11, 5'd10, 3'd5, 5'd9), enc_s(12'd4, 5'd12, 5'd0)});
      do_reset(1);
      step(2);
      check("srl_x9", dut.regs.regs[9], 32'h3);
      check("sb_mem4", {24'd0, dut.datamem.mem[4]}, 32'h0F);
      check("sb_mem3", {24'd0, dut.datamem.mem[3]}, 32'hAA);
      check("sb_mem5", {24'd0, dut.datamem.mem[5]}, 32'hBB);

      // beq taken skips, bne not taken falls through
      set_reg(14, 32'h0);
      load_prog('{enc_b(8, 5'd0, 5'd0, 3'd0), enc_i(12'd1, 5'd0, 3'd0, 5'd14, 7'h13),
                  enc_b(8, 5'd0, 5'd0, 3'd1), enc_i(12'd2, 5'd0, 3'd0, 5'd19, 7'h13)});
      do_reset(1);
      step(1);
      check("beq_pc", pc, 32'd8);
      step(1);
      check("bne_pc", pc, 32'd12);
      check("beq_x14", dut.regs.regs[14], 32'h0);

      // x0 never written and reads zero; store address wraps
      dut.regs.regs[0] = 32'h0000_1234;
      set_reg(17, 32'h5A);
      load_prog('{enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), enc_i(12'd3, 5'd0, 3'd0, 5'd15, 7'h13),
                  enc_i(12'h080, 5'd0, 3'd0, 5'd16, 7'h13), enc_s(12'd0, 5'd17, 5'd16)});
      do_reset(1);
      step(4);
      check("x0_nowrite", dut.regs.regs[0], 32'h0000_1234);
      check("x0_reads0", dut.regs.regs[15], 32'h3);
      check("sb_wrap", {24'd0, dut.datamem.mem[0]}, 32'h5A);
      dut.regs.regs[0] = 32'h0;

      // reset mid-program aborts the pending store
      set_reg(20, 32'd100);
      set_mem(8, 8'h33);
      load_prog('{enc_i(12'd1, 5'd20, 3'd0, 5'd20, 7'h13), enc_i(12'd1, 5'd20, 3'd0, 5'd20, 7'h13),
                  enc_s(12'd8, 5'd20, 5'd0), enc_i(12'd7, 5'd0, 3'd0, 5'd21, 7'h13)});
      do_reset(1);
      step(2);
      check("pre_reset_pc", pc, 32'd8);
      do_reset(2);
      check("rst_x20", dut.regs.regs[20], 32'd102);
      check("rst_mem8", {24'd0, dut.datamem.mem[8]}, 32'h33);
      step(1);
      check("restart_x20", dut.regs.regs[20], 32'd103);

      // randomized programs against the model
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i < 32; i++) set_reg(i, $urandom);
         for (int i = 0; i < DMEM; i++) set_mem(i, 8'($urandom));
         prog.delete();
         for (int i = 0; i < 48; i++) prog.push_back(rand_instr(48));
         load_prog(prog);
         do_reset(1);
         step(150);
         for (int i = 0; i < 32; i++) check("rand_reg", dut.regs.regs[i], m_regs[i]);
         for (int i = 0; i < DMEM; i++) check("rand_mem", {24'd0, dut.datamem.mem[i]}, {24'd0, m_mem[i]});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
